// File: rtl/aes128_round_sched.sv
`default_nettype none
// ============================================================================
// Module   : aes128_round_sched
// Purpose  : Iterative AES-128 encryption controller. Performs the initial
//            AddRoundKey, then walks an external single-cycle combinational
//            round datapath through NR rounds, holding the state and round-key
//            registers between rounds.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready/in_pt/in_key  - plaintext + key source
//            abort                           - synchronous abandon of block
//            rnd_rc/rnd_last/rnd_data/rnd_key -> round datapath
//            rnd_out/rnd_key_out             <- round datapath results
//            out_valid/out_ready/out_ct      - ciphertext sink
//            busy                            - high while a block is in flight
// Options  : AES_SCHED_ZEROIZE_EN - when defined, state and key registers are
//            cleared on output handshake and on abort.
// Revision : 1.0 - initial release
// ============================================================================
module aes128_round_sched #(
    parameter int NR   = 10,
    parameter int RC_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    in_pt,
    input  logic [127:0]    in_key,
    input  logic            abort,
    output logic [RC_W-1:0] rnd_rc,
    output logic            rnd_last,
    output logic [127:0]    rnd_data,
    output logic [127:0]    rnd_key,
    input  logic [127:0]    rnd_out,
    input  logic [127:0]    rnd_key_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out_ct,
    output logic            busy
);

    localparam logic [RC_W-1:0] C_RC_ZERO  = '0;
    localparam logic [RC_W-1:0] C_RC_FIRST = RC_W'(1);
    localparam logic [RC_W-1:0] C_RC_LAST  = RC_W'(NR);

`ifdef AES_SCHED_ZEROIZE_EN
    localparam logic C_ZEROIZE = 1'b1;
`else
    localparam logic C_ZEROIZE = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [RC_W-1:0]   rc_q,        rc_d;
    logic [127:0]      st_q,        st_d;
    logic [127:0]      key_q,       key_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q,      busy_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        st_d    = st_q;
        key_d   = key_q;

        if (abort) begin
            // Abort overrides everything, including a concurrent accept.
            state_d = S_IDLE;
            rc_d    = C_RC_ZERO;
            if (C_ZEROIZE) begin
                st_d  = '0;
                key_d = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        st_d    = in_pt ^ in_key;   // initial AddRoundKey
                        key_d   = in_key;
                        rc_d    = C_RC_FIRST;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    st_d  = rnd_out;
                    key_d = rnd_key_out;
                    // Compare with >= so a corrupted count can never run past
                    // the last round or wrap.
                    if (rc_q >= C_RC_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        rc_d = rc_q + C_RC_FIRST;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                        rc_d    = C_RC_ZERO;
                        if (C_ZEROIZE) begin
                            st_d  = '0;
                            key_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    rc_d    = C_RC_ZERO;
                end
            endcase
        end

        // Handshake flags are registered copies of the next-state decode.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rc_q        <= C_RC_ZERO;
            st_q        <= '0;
            key_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rc_q        <= rc_d;
            st_q        <= st_d;
            key_q       <= key_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The round count is only meaningful to the datapath while running;
    // outside RUN it reads as zero.
    assign rnd_rc    = (state_q == S_RUN) ? rc_q : C_RC_ZERO;
    assign rnd_last  = (state_q == S_RUN) && (rc_q == C_RC_LAST);
    assign rnd_data  = st_q;
    assign rnd_key   = key_q;
    assign out_ct    = st_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire
